// File: rtl/pe_array_seq.sv
// Tile sequencer for the PE array: per-tile loader handshake, buffer flip, start/done
// collection, and accumulation-buffer swap plus readout after each accumulation group.
module pe_array_seq #(
    parameter int PE_NUM = 32,
    parameter int ADDR_W = 8,
    parameter int RD_LAT = 2,
    localparam int GRP_NUM = PE_NUM / 4,
    localparam int SEL_W = (GRP_NUM > 1) ? $clog2(GRP_NUM) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [2:0]        cfg_mode,
    input  logic [7:0]        cfg_idx_cnt,
    input  logic [7:0]        cfg_trip_cnt,
    input  logic [3:0]        cfg_pad_code,
    input  logic              cfg_cut_y,
    input  logic [PE_NUM-1:0] cfg_pe_mask,
    input  logic [15:0]       cfg_tile_num,
    input  logic [7:0]        cfg_acc_num,
    input  logic [ADDR_W:0]   cfg_rd_len,
    input  logic              ld_valid,
    output logic              ld_ready,
    output logic [PE_NUM-1:0] switch_d,
    output logic [PE_NUM-1:0] switch_p,
    output logic [PE_NUM-1:0] switch_i,
    output logic [PE_NUM-1:0] switch_a,
    output logic [PE_NUM-1:0] start,
    input  logic [PE_NUM-1:0] done,
    output logic [2:0]        mode,
    output logic [7:0]        idx_cnt,
    output logic [7:0]        trip_cnt,
    output logic [3:0]        pad_code,
    output logic              cut_y,
    output logic              is_new,
    output logic [SEL_W-1:0]  rd_sel,
    output logic [ADDR_W-1:0] abuf_rd_addr,
    input  logic              wb_ready,
    output logic              rd_valid,
    output logic              busy,
    output logic              layer_done
);
    localparam int LEN_W = ADDR_W + 1;
    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(GRP_NUM - 1);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] WAIT_LD = 3'd1;
    localparam logic [2:0] SWITCH  = 3'd2;
    localparam logic [2:0] START   = 3'd3;
    localparam logic [2:0] RUN     = 3'd4;
    localparam logic [2:0] SWAP_A  = 3'd5;
    localparam logic [2:0] READ    = 3'd6;
    localparam logic [2:0] DONE    = 3'd7;

    logic [2:0]        state_q, state_d;
    logic [PE_NUM-1:0] mask_q, mask_d;
    logic [15:0]       tile_num_q, tile_num_d, tile_cnt_q, tile_cnt_d;
    logic [7:0]        acc_num_q, acc_num_d, acc_cnt_q, acc_cnt_d;
    logic [LEN_W-1:0]  rd_len_q, rd_len_d;
    logic [PE_NUM-1:0] done_seen_q, done_seen_d;
    logic [RD_LAT-1:0] vld_q, vld_d;
    logic [2:0]        mode_q, mode_d;
    logic [7:0]        idx_cnt_q, idx_cnt_d, trip_cnt_q, trip_cnt_d;
    logic [3:0]        pad_code_q, pad_code_d;
    logic              cut_y_q, cut_y_d, is_new_q, is_new_d;
    logic [SEL_W-1:0]  rd_sel_q, rd_sel_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [PE_NUM-1:0] switch_d_q, switch_d_d, switch_p_q, switch_p_d;
    logic [PE_NUM-1:0] switch_i_q, switch_i_d, switch_a_q, switch_a_d;
    logic [PE_NUM-1:0] start_q, start_d;
    logic              cfg_ready_q, cfg_ready_d, ld_ready_q, ld_ready_d;
    logic              busy_q, busy_d, layer_done_q, layer_done_d;
    logic              issue, acc_last;

    // acc_num of 0 behaves as 1, i.e. every tile closes its group
    assign acc_last = (acc_num_q == 8'd0) ? (acc_cnt_q == 8'd0)
                                          : (acc_cnt_q == acc_num_q - 8'd1);

    always_comb begin
        state_d     = state_q;
        mask_d      = mask_q;
        tile_num_d  = tile_num_q;
        tile_cnt_d  = tile_cnt_q;
        acc_num_d   = acc_num_q;
        acc_cnt_d   = acc_cnt_q;
        rd_len_d    = rd_len_q;
        done_seen_d = done_seen_q;
        mode_d      = mode_q;
        idx_cnt_d   = idx_cnt_q;
        trip_cnt_d  = trip_cnt_q;
        pad_code_d  = pad_code_q;
        cut_y_d     = cut_y_q;
        is_new_d    = is_new_q;
        rd_sel_d    = rd_sel_q;
        addr_d      = addr_q;
        issue       = 1'b0;
        layer_done_d = 1'b0;
        case (state_q)
            IDLE: if (cfg_valid) begin
                mask_d     = cfg_pe_mask;
                tile_num_d = cfg_tile_num;
                acc_num_d  = cfg_acc_num;
                rd_len_d   = cfg_rd_len;
                mode_d     = cfg_mode;
                idx_cnt_d  = cfg_idx_cnt;
                trip_cnt_d = cfg_trip_cnt;
                pad_code_d = cfg_pad_code;
                cut_y_d    = cfg_cut_y;
                tile_cnt_d = 16'd0;
                acc_cnt_d  = 8'd0;
                state_d    = (cfg_tile_num == 16'd0) ? DONE : WAIT_LD;
            end
            WAIT_LD: if (ld_valid) begin
                is_new_d = (acc_cnt_q == 8'd0);
                state_d  = SWITCH;
            end
            SWITCH: state_d = START;
            START: begin
                done_seen_d = '0;
                state_d     = RUN;
            end
            RUN: begin
                done_seen_d = done_seen_q | (done & mask_q);
                if (done_seen_d == mask_q) begin
                    tile_cnt_d = tile_cnt_q + 16'd1;
                    if (acc_last || tile_cnt_d == tile_num_q) begin
                        state_d = SWAP_A;
                    end else begin
                        acc_cnt_d = acc_cnt_q + 8'd1;
                        state_d   = WAIT_LD;
                    end
                end
            end
            SWAP_A: begin
                acc_cnt_d = 8'd0;
                rd_sel_d  = '0;
                addr_d    = '0;
                if (rd_len_q == '0) begin
                    state_d = (tile_cnt_q == tile_num_q) ? DONE : WAIT_LD;
                end else begin
                    state_d = READ;
                end
            end
            READ: if (wb_ready) begin
                issue = 1'b1;
                if ({1'b0, addr_q} == rd_len_q - LEN_W'(1)) begin
                    addr_d = '0;
                    if (rd_sel_q == SEL_LAST) begin
                        rd_sel_d = '0;
                        state_d  = (tile_cnt_q == tile_num_q) ? DONE : WAIT_LD;
                    end else begin
                        rd_sel_d = rd_sel_q + SEL_W'(1);
                    end
                end else begin
                    addr_d = addr_q + ADDR_W'(1);
                end
            end
            default: if (vld_q == '0) begin
                layer_done_d = 1'b1;
                state_d      = IDLE;
            end
        endcase

        // Read-valid pipeline runs in every state so a readout drains after READ exits
        vld_d[0] = issue;
        for (int i = 1; i < RD_LAT; i++) vld_d[i] = vld_q[i-1];

        // Outputs decode the next state so they are registered alongside it
        switch_d_d  = (state_d == SWITCH) ? mask_d : '0;
        switch_p_d  = (state_d == SWITCH) ? mask_d : '0;
        switch_i_d  = (state_d == SWITCH) ? mask_d : '0;
        start_d     = (state_d == START)  ? mask_d : '0;
        switch_a_d  = (state_d == SWAP_A) ? mask_d : '0;
        cfg_ready_d = (state_d == IDLE);
        ld_ready_d  = (state_d == WAIT_LD);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            mask_q       <= '0;
            tile_num_q   <= '0;
            tile_cnt_q   <= '0;
            acc_num_q    <= '0;
            acc_cnt_q    <= '0;
            rd_len_q     <= '0;
            done_seen_q  <= '0;
            vld_q        <= '0;
            mode_q       <= '0;
            idx_cnt_q    <= '0;
            trip_cnt_q   <= '0;
            pad_code_q   <= '0;
            cut_y_q      <= 1'b0;
            is_new_q     <= 1'b0;
            rd_sel_q     <= '0;
            addr_q       <= '0;
            switch_d_q   <= '0;
            switch_p_q   <= '0;
            switch_i_q   <= '0;
            switch_a_q   <= '0;
            start_q      <= '0;
            cfg_ready_q  <= 1'b1;
            ld_ready_q   <= 1'b0;
            busy_q       <= 1'b0;
            layer_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            mask_q       <= mask_d;
            tile_num_q   <= tile_num_d;
            tile_cnt_q   <= tile_cnt_d;
            acc_num_q    <= acc_num_d;
            acc_cnt_q    <= acc_cnt_d;
            rd_len_q     <= rd_len_d;
            done_seen_q  <= done_seen_d;
            vld_q        <= vld_d;
            mode_q       <= mode_d;
            idx_cnt_q    <= idx_cnt_d;
            trip_cnt_q   <= trip_cnt_d;
            pad_code_q   <= pad_code_d;
            cut_y_q      <= cut_y_d;
            is_new_q     <= is_new_d;
            rd_sel_q     <= rd_sel_d;
            addr_q       <= addr_d;
            switch_d_q   <= switch_d_d;
            switch_p_q   <= switch_p_d;
            switch_i_q   <= switch_i_d;
            switch_a_q   <= switch_a_d;
            start_q      <= start_d;
            cfg_ready_q  <= cfg_ready_d;
            ld_ready_q   <= ld_ready_d;
            busy_q       <= busy_d;
            layer_done_q <= layer_done_d;
        end
    end

    assign cfg_ready    = cfg_ready_q;
    assign ld_ready     = ld_ready_q;
    assign switch_d     = switch_d_q;
    assign switch_p     = switch_p_q;
    assign switch_i     = switch_i_q;
    assign switch_a     = switch_a_q;
    assign start        = start_q;
    assign mode         = mode_q;
    assign idx_cnt      = idx_cnt_q;
    assign trip_cnt     = trip_cnt_q;
    assign pad_code     = pad_code_q;
    assign cut_y        = cut_y_q;
    assign is_new       = is_new_q;
    assign rd_sel       = rd_sel_q;
    assign abuf_rd_addr = addr_q;
    assign rd_valid     = vld_q[RD_LAT-1];
    assign busy         = busy_q;
    assign layer_done   = layer_done_q;
endmodule

// File: tb/tb_pe_array_seq.sv
// Directed bench for pe_array_seq: a PE done responder and readout monitor run alongside
// a linear sequence of jobs; each job's pulse counts, timing and readout order are checked.
module tb_pe_array_seq;
    localparam int PE_NUM = 32;
    localparam int GRP = PE_NUM / 4;

    logic clk, rst;
    logic cfg_valid, cfg_ready, cfg_cut_y, ld_valid, ld_ready;
    logic [2:0] cfg_mode, mode;
    logic [7:0] cfg_idx_cnt, cfg_trip_cnt, cfg_acc_num, idx_cnt, trip_cnt;
    logic [3:0] cfg_pad_code, pad_code;
    logic [PE_NUM-1:0] cfg_pe_mask, switch_d, switch_p, switch_i, switch_a, start, done;
    logic [15:0] cfg_tile_num;
    logic [8:0] cfg_rd_len;
    logic cut_y, is_new, wb_ready, rd_valid, busy, layer_done;
    logic [2:0] rd_sel;
    logic [7:0] abuf_rd_addr;

    pe_array_seq dut (
        .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_mode(cfg_mode), .cfg_idx_cnt(cfg_idx_cnt), .cfg_trip_cnt(cfg_trip_cnt),
        .cfg_pad_code(cfg_pad_code), .cfg_cut_y(cfg_cut_y), .cfg_pe_mask(cfg_pe_mask),
        .cfg_tile_num(cfg_tile_num), .cfg_acc_num(cfg_acc_num), .cfg_rd_len(cfg_rd_len),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .switch_d(switch_d), .switch_p(switch_p),
        .switch_i(switch_i), .switch_a(switch_a), .start(start), .done(done),
        .mode(mode), .idx_cnt(idx_cnt), .trip_cnt(trip_cnt), .pad_code(pad_code),
        .cut_y(cut_y), .is_new(is_new), .rd_sel(rd_sel), .abuf_rd_addr(abuf_rd_addr),
        .wb_ready(wb_ready), .rd_valid(rd_valid), .busy(busy), .layer_done(layer_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    int dly [PE_NUM];
    int scnt = 1000;
    logic wb_pat_en = 1'b0;
    logic [3:0] wb_pat = 4'b1001;
    int wb_ph = 0;
    int n_sw = 0, n_start = 0, n_swa = 0, n_rdv = 0, n_ld = 0, n_ldone = 0;
    int seq_err = 0, pulse_err = 0, swa_at = 0, k_ro = 0;
    int h_sel [2], h_addr [2];
    logic [7:0] isnew_hist = '0;
    int b_sw, b_start, b_swa, b_rdv, b_ld, b_ldone;

    // PE done responder, writeback-ready pattern and output monitor, all on the falling edge
    always @(negedge clk) begin
        if (wb_pat_en) begin
            wb_ready = wb_pat[wb_ph];
            wb_ph = (wb_ph + 1) % 4;
        end else begin
            wb_ready = 1'b1;
        end
        if (start != '0) scnt = 0;
        else if (scnt < 1000) scnt++;
        for (int i = 0; i < PE_NUM; i++) done[i] = (scnt == dly[i]);
        if (rd_valid) begin
            if (h_sel[1] != k_ro / int'(cfg_rd_len) || h_addr[1] != k_ro % int'(cfg_rd_len))
                seq_err++;
            k_ro++;
            n_rdv++;
        end
        h_sel[1] = h_sel[0];
        h_addr[1] = h_addr[0];
        h_sel[0] = int'(rd_sel);
        h_addr[0] = int'(abuf_rd_addr);
        if (switch_a != '0) begin
            n_swa++;
            swa_at = scnt;
            k_ro = 0;
            if (switch_a != cfg_pe_mask) pulse_err++;
        end
        if (switch_d != '0 || switch_p != '0 || switch_i != '0) begin
            n_sw++;
            if (switch_d != cfg_pe_mask || switch_p != cfg_pe_mask || switch_i != cfg_pe_mask)
                pulse_err++;
            isnew_hist = {isnew_hist[6:0], is_new};
        end
        if (start != '0) begin
            n_start++;
            if (start != cfg_pe_mask) pulse_err++;
        end
        if (ld_ready && ld_valid) n_ld++;
        if (layer_done) n_ldone++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic snap();
        b_sw = n_sw; b_start = n_start; b_swa = n_swa;
        b_rdv = n_rdv; b_ld = n_ld; b_ldone = n_ldone;
    endtask

    task automatic accept(input logic [15:0] tn, input logic [7:0] an,
                          input logic [PE_NUM-1:0] mk, input logic [8:0] rl);
        logic got;
        got = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (cfg_ready) begin got = 1'b1; break; end
        end
        check("cfg_ready_wait", got, 1);
        cfg_tile_num = tn; cfg_acc_num = an; cfg_pe_mask = mk; cfg_rd_len = rl;
        snap();
        cfg_valid = 1'b1;
        @(posedge clk);
        #1 cfg_valid = 1'b0;
    endtask

    task automatic run_job(input logic [15:0] tn, input logic [7:0] an,
                           input logic [PE_NUM-1:0] mk, input logic [8:0] rl);
        logic got;
        accept(tn, an, mk, rl);
        got = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (layer_done) begin got = 1'b1; break; end
        end
        check("layer_done_seen", got, 1);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        rst = 1'b0; cfg_valid = 1'b0; ld_valid = 1'b1;
        cfg_mode = 3'd5; cfg_idx_cnt = 8'h21; cfg_trip_cnt = 8'h47;
        cfg_pad_code = 4'h9; cfg_cut_y = 1'b1;
        cfg_pe_mask = '0; cfg_tile_num = '0; cfg_acc_num = '0; cfg_rd_len = '0;
        for (int i = 0; i < PE_NUM; i++) dly[i] = 5;
        repeat (3) @(negedge clk);
        check("rst_cfg_ready", cfg_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_ld_ready", ld_ready, 0);
        check("rst_rd_sel_addr", {rd_sel, abuf_rd_addr}, 0);
        check("rst_mode", mode, 0);
        rst = 1'b1;

        // Single tile, full mask, 4 words per group
        run_job(16'd1, 8'd1, '1, 9'd4);
        check("t1_switch", n_sw - b_sw, 1);
        check("t1_start", n_start - b_start, 1);
        check("t1_swa", n_swa - b_swa, 1);
        check("t1_rdv", n_rdv - b_rdv, 32);
        check("t1_ld", n_ld - b_ld, 1);
        check("t1_ldone", n_ldone - b_ldone, 1);
        check("t1_run_len", swa_at, 6);
        check("t1_is_new", isnew_hist[0], 1);
        check("t1_fields", {mode, idx_cnt, trip_cnt, pad_code, cut_y}, {3'd5, 8'h21, 8'h47, 4'h9, 1'b1});
        check("t1_idle", {cfg_ready, busy}, 2'b10);

        // Four tiles accumulated in pairs
        run_job(16'd4, 8'd2, '1, 9'd2);
        check("t2_switch", n_sw - b_sw, 4);
        check("t2_is_new", isnew_hist[3:0], 4'b1010);
        check("t2_swa", n_swa - b_swa, 2);
        check("t2_rdv", n_rdv - b_rdv, 2 * GRP * 2);
        check("t2_ld", n_ld - b_ld, 4);
        check("t2_ldone", n_ldone - b_ldone, 1);

        // Three tiles in pairs: the last tile flushes a partial group
        run_job(16'd3, 8'd2, '1, 9'd1);
        check("t3_is_new", isnew_hist[2:0], 3'b101);
        check("t3_swa", n_swa - b_swa, 2);
        check("t3_rdv", n_rdv - b_rdv, 2 * GRP);
        check("t3_ldone", n_ldone - b_ldone, 1);

        // Partial mask: unmasked PEs report early, masked PEs report at 3,6,4,9
        for (int i = 4; i < PE_NUM; i++) dly[i] = 1;
        dly[0] = 3; dly[1] = 6; dly[2] = 4; dly[3] = 9;
        run_job(16'd1, 8'd1, 32'h0000_000F, 9'd1);
        check("t4_run_len", swa_at, 10);
        check("t4_start", n_start - b_start, 1);
        check("t4_rdv", n_rdv - b_rdv, GRP);
        check("t4_pulse_mask", pulse_err, 0);
        for (int i = 0; i < PE_NUM; i++) dly[i] = 5;

        // Writeback back-pressure 1,0,0,1 during readout
        wb_pat_en = 1'b1;
        run_job(16'd1, 8'd1, '1, 9'd3);
        wb_pat_en = 1'b0;
        check("t5_rdv", n_rdv - b_rdv, GRP * 3);
        check("t5_order", seq_err, 0);

        // Empty job
        accept(16'd0, 8'd1, '1, 9'd2);
        @(negedge clk);
        check("t6_ldone_early", layer_done, 0);
        @(negedge clk);
        check("t6_ldone", layer_done, 1);
        repeat (3) @(negedge clk);
        check("t6_no_pulses", {n_sw - b_sw, n_start - b_start, n_ld - b_ld}, 0);

        // Reset in the middle of RUN
        for (int i = 0; i < PE_NUM; i++) dly[i] = 20;
        cfg_mode = 3'd6;
        accept(16'd2, 8'd1, '1, 9'd1);
        begin
            logic got;
            got = 1'b0;
            for (int i = 0; i < 100; i++) begin
                @(negedge clk);
                if (start != '0) begin got = 1'b1; break; end
            end
            check("t7_start_seen", got, 1);
        end
        repeat (3) @(negedge clk);
        snap();
        rst = 1'b0;
        #1;
        check("t7_rst_busy", busy, 0);
        check("t7_rst_pulses", {start, switch_d, switch_a, rd_valid, layer_done}, 0);
        check("t7_rst_fields", {mode, is_new, rd_sel, abuf_rd_addr}, 0);
        check("t7_rst_ready", cfg_ready, 1);
        @(negedge clk);
        rst = 1'b1;
        repeat (30) @(negedge clk);
        check("t7_no_ldone", n_ldone - b_ldone, 0);
        check("t7_no_start", n_start - b_start, 0);
        check("t7_idle", {cfg_ready, busy, ld_ready}, 3'b100);
        check("all_pulse_masks", pulse_err, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pe_array_seq.md
Name: pe_array_seq

Overview:
Tile sequencer for the PE array. It accepts one layer job, then for each tile: handshakes with the buffer loader, flips the PE ping-pong buffers, starts the masked PEs and collects their done flags. After every ACC group of tiles it swaps the accumulation buffers and streams every group's accumulation buffer out through rd_sel/abuf_rd_addr. It sits between the layer-level controller and the PE array control/readout ports.

Parameters:
PE_NUM, 32, number of PEs; must be a multiple of 4
GRP_NUM, PE_NUM/4, number of PE groups (derived)
ADDR_W, 8, accumulation buffer address width
RD_LAT, 2, cycles from abuf_rd_addr/rd_sel to valid abuf_rd_data (BRAM plus array output register)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
cfg_valid  in  1  job valid
cfg_ready  out  1  high only in IDLE
cfg_mode  in  3  PE mode
cfg_idx_cnt  in  8  index count
cfg_trip_cnt  in  8  trip count
cfg_pad_code  in  4  padding code
cfg_cut_y  in  1  cut_y flag
cfg_pe_mask  in  PE_NUM  PEs taking part in the job
cfg_tile_num  in  16  tiles in the job
cfg_acc_num  in  8  tiles accumulated per output; 0 is treated as 1
cfg_rd_len  in  ADDR_W+1  words read per group at readout
ld_valid  in  1  shadow data/param/idx buffers loaded
ld_ready  out  1  high only in WAIT_LD
switch_d, switch_p, switch_i, switch_a  out  PE_NUM each  one-cycle swap pulses
start  out  PE_NUM  one-cycle start pulse
done  in  PE_NUM  PE done pulses
mode, idx_cnt, trip_cnt, pad_code, cut_y  out  3/8/8/4/1  latched job fields
is_new  out  1  current tile opens a new accumulation
rd_sel  out  clog2(GRP_NUM)  group being read
abuf_rd_addr  out  ADDR_W  readout address
wb_ready  in  1  writeback can take a word
rd_valid  out  1  abuf_rd_data valid this cycle
busy  out  1  not IDLE
layer_done  out  1  one-cycle pulse at job end

Behaviour:
- Reset (rst low, async): state=IDLE. All pulse outputs, rd_valid, layer_done, busy, is_new, rd_sel and abuf_rd_addr are 0. Latched fields are 0. The RD_LAT pipeline is cleared. Reset mid-job abandons the job; no outputs pulse after reset is released.
- All outputs are registered.
- IDLE: cfg_ready=1. When cfg_valid is high, latch all cfg_* fields and clear tile_cnt and acc_cnt.
  - If tile_num=0, go to DONE.
  - Otherwise go to WAIT_LD.
- WAIT_LD: ld_ready=1. When ld_valid is high, go to SWITCH.
- SWITCH, 1 cycle:
  - switch_d=switch_p=switch_i=mask.
  - is_new <= (acc_cnt==0). is_new holds until the next SWITCH.
  - Go to START.
- START, 1 cycle: start=mask; clear done_seen. Go to RUN.
- RUN:
  - done_seen |= done & mask. Bits outside the mask are ignored.
  - done is sampled from the cycle after the start pulse onward.
  - When (done_seen | (done & mask)) == mask: tile_cnt++, and go to SWAP_A if acc_cnt==acc_num-1 or this tile is the last; otherwise acc_cnt++ and go to WAIT_LD.
  - mask=0 completes on the first RUN cycle.
- SWAP_A, 1 cycle: switch_a=mask; acc_cnt=0; rd_sel=0; abuf_rd_addr=0. Go to READ.
- READ:
  - A read issues in each cycle where wb_ready=1. The issued address is abuf_rd_addr with rd_sel.
  - After an issue, abuf_rd_addr increments. When it reaches rd_len-1, it wraps to 0 and rd_sel increments.
  - After the read of group GRP_NUM-1 at address rd_len-1: go to DONE if tile_cnt==tile_num, else WAIT_LD.
  - When wb_ready=0, address and rd_sel hold and nothing issues.
  - rd_len=0 skips READ entirely.
- rd_valid is the issue strobe delayed by RD_LAT cycles. This pipeline keeps running in every state, so a readout drains even after leaving READ.
- DONE: waits until the rd_valid pipeline is empty, then pulses layer_done for 1 cycle and goes to IDLE.
- busy=1 in every state except IDLE.
- Widths:
  - tile_cnt is 16 bits; acc_cnt is 8 bits; the tile_num comparison is exact with no wrap.
  - The done_seen register is PE_NUM wide.

Test Plan:
1. tile_num=1, acc_num=1, mask=all 1s, rd_len=4, wb_ready=1. Done from all PEs 5 cycles after start -> one switch_d/p/i pulse, start, switch_a, then 32 issues (rd_sel 0..7 × addr 0..3), 32 rd_valid pulses each RD_LAT later, layer_done once, cfg_ready back to 1.
2. tile_num=4, acc_num=2 -> is_new pattern 1,0,1,0; switch_a and a readout after tiles 2 and 4 only; 4 ld handshakes.
3. tile_num=3, acc_num=2 -> readouts after tile 2 and after tile 3 (flush); layer_done after the second readout drains.
4. mask=0x0000000F; PEs 4..31 pulse done early, PEs 0..3 done in different cycles -> RUN exits only after the last of PEs 0..3 reports; start and switch outputs are 0 on bits 4..31.
5. wb_ready toggled 1,0,0,1 during READ -> address advances only on wb_ready=1 cycles; rd_valid count equals GRP_NUM×rd_len.
6. tile_num=0 -> layer_done pulse about 2 cycles after accept, no start or switch pulses. Then rst low in the middle of RUN on a new job -> all outputs 0 immediately, IDLE after release, no layer_done.
